gray_count_receiver: RTL and testbench



---
 rtl/gray_count_receiver_pkg.sv | 23 ++
 rtl/gray_count_receiver_sync_stages.sv | 37 +++
 rtl/gray_count_receiver.sv | 88 ++++++++
 tb/tb_gray_count_receiver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_count_receiver_pkg.sv
// Gray-count helpers shared by the sending counter and the receiving decoder.
// Latency: combinational functions only. Backpressure: none.
// Both functions work on any width up to GRAY_MAX_W: pass the value zero-extended and truncate the result.
package gray_count_receiver_pkg;

    localparam int N_SYNC_DEFAULT = 2;
    localparam int GRAY_MAX_W     = 32;

    // Zero upper bits keep the XOR chain at 0 until the real MSB, so the low bits decode exactly.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_count_receiver_sync_stages.sv
// W-wide, N-deep synchroniser chain with async reset and synchronous clear.
// Latency: N clocks. Backpressure: none; samples every clock.
module gray_sync_stages
    import gray_count_receiver_pkg::*;
#(
    parameter int W = 4,
    parameter int N = N_SYNC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // First stage may go metastable: keep it, place stages together, never retime.
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [W-1:0] meta;
    logic [W-1:0] tail [N-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            for (int i = 0; i < N-1; i++) tail[i] <= '0;
        end else if (clr) begin
            meta <= '0;
            for (int i = 0; i < N-1; i++) tail[i] <= '0;
        end else begin
            meta    <= d;
            tail[0] <= meta;
            for (int i = 1; i < N-1; i++) tail[i] <= tail[i-1];
        end
    end

    assign q = tail[N-2];

endmodule

// File: rtl/gray_count_receiver.sv
// Synchronises a remote Gray count, decodes it, and reports level/empty/advance vs a local count.
// Latency: gry_in to count_bin N_SYNC+1 clocks; local_bin to level/empty 0. Backpressure: none.
// Optional GRAY_RX_ERR_CHECK_EN adds a sticky multi-bit-change detector on the synchronised count.
module gray_count_receiver
    import gray_count_receiver_pkg::*;
#(
    parameter int W_CTR  = 4,
    parameter int N_SYNC = N_SYNC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_CTR-1:0] gry_in,
    input  logic             clr,
    input  logic [W_CTR-1:0] local_bin,
    output logic [W_CTR-1:0] count_bin,
    output logic [W_CTR-1:0] level,
    output logic             empty,
    output logic             advanced,
    output logic             err
);

    logic [W_CTR-1:0] gry_s;
    logic [W_CTR-1:0] dec_bin;

    gray_sync_stages #(.W(W_CTR), .N(N_SYNC)) u_sync (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .d   (gry_in),
        .q   (gry_s)
    );

    assign dec_bin = W_CTR'(gray2bin(GRAY_MAX_W'(gry_s)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_bin <= '0;
            advanced  <= 1'b0;
        end else if (clr) begin
            count_bin <= '0;
            advanced  <= 1'b0;
        end else begin
            count_bin <= dec_bin;
            advanced  <= (dec_bin != count_bin);
        end
    end

    assign level = count_bin - local_bin;
    assign empty = (level == '0);

`ifdef GRAY_RX_ERR_CHECK_EN
    logic [W_CTR-1:0]  gry_s_prev;
    logic [W_CTR-1:0]  gry_diff;
    logic [N_SYNC-1:0] s_vld_pipe;
    logic              prev_vld;
    logic              err_q;

    assign gry_diff = gry_s ^ gry_s_prev;

    // Compare only once both samples come from after the last clear, so the refill jump is not flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gry_s_prev <= '0;
            s_vld_pipe <= '0;
            prev_vld   <= 1'b0;
            err_q      <= 1'b0;
        end else if (clr) begin
            gry_s_prev <= '0;
            s_vld_pipe <= '0;
            prev_vld   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            gry_s_prev <= gry_s;
            s_vld_pipe <= {s_vld_pipe[N_SYNC-2:0], 1'b1};
            prev_vld   <= s_vld_pipe[N_SYNC-1];
            if (prev_vld && s_vld_pipe[N_SYNC-1] &&
                ((gry_diff & (gry_diff - W_CTR'(1))) != '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_count_receiver.sv
// Directed bench for gray_count_receiver: stimulus queues expected advance events, a monitor checks them.
module tb_gray_count_receiver;

    localparam int W = 4;
`ifdef GRAY_RX_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [W-1:0] gry_in;
    logic [W-1:0] local_bin;
    logic [W-1:0] count_bin;
    logic [W-1:0] level;
    logic         empty;
    logic         advanced;
    logic         err;

    always #5 clk = ~clk;

    gray_count_receiver #(.W_CTR(W), .N_SYNC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .gry_in    (gry_in),
        .clr       (clr),
        .local_bin (local_bin),
        .count_bin (count_bin),
        .level     (level),
        .empty     (empty),
        .advanced  (advanced),
        .err       (err)
    );

    typedef struct {
        logic [W-1:0] cnt;
        logic [W-1:0] lvl;
        logic         e;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Gray codes of 0..15, written out by hand.
    logic [W-1:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] cnt, input logic [W-1:0] lvl, input logic e);
        exp_t x;
        x.cnt = cnt;
        x.lvl = lvl;
        x.e   = e;
        x.cyc = cyc + 3;
        sb.push_back(x);
    endtask

    // Drive one Gray value at a negedge, expect its decode three edges later, hold for 'hold' cycles.
    task automatic step(input logic [W-1:0] g, input logic [W-1:0] bin, input logic e, input int hold);
        @(negedge clk);
        gry_in = g;
        push_exp(bin, W'(bin - local_bin), e);
        repeat (hold - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (advanced === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_advance: count_bin %0d at cycle %0d with none queued", count_bin, cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("adv_cycle", cyc, x.cyc);
                check("adv_count_bin", count_bin, x.cnt);
                check("adv_level", level, x.lvl);
                check("adv_empty", empty, (x.lvl == '0));
                check("adv_err", err, x.e);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        gry_in    = '0;
        local_bin = '0;

        // Reset state, including the combinational level under reset.
        #12;
        check("rst_count_bin", count_bin, 0);
        check("rst_advanced", advanced, 0);
        check("rst_err", err, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        local_bin = 4'd3;
        #1;
        check("rst_level_lb3", level, 13);
        check("rst_empty_lb3", empty, 0);
        local_bin = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("idle_count_bin", count_bin, 0);
            check("idle_empty", empty, 1);
            check("idle_advanced", advanced, 0);
            check("idle_err", err, 0);
        end

        // Gray 0 -> 1 -> 3 -> 2 held five clocks each.
        step(4'd1, 4'd1, 1'b0, 5);
        step(4'd3, 4'd2, 1'b0, 5);
        step(4'd2, 4'd3, 1'b0, 5);

        // Full Gray walk with wrap, local_bin = 14: level 1 at 15, 2 at 0.
        @(negedge clk);
        local_bin = 4'd14;
        for (int n = 0; n < 16; n++) step(gtab[n], 4'(n), 1'b0, 4);
        step(4'd0, 4'd0, 1'b0, 6);

        // Walk up to 5, then a one-cycle clr with gry_in held at Gray(5)=7.
        @(negedge clk);
        local_bin = '0;
        step(4'd1, 4'd1, 1'b0, 4);
        step(4'd3, 4'd2, 1'b0, 4);
        step(4'd2, 4'd3, 1'b0, 4);
        step(4'd6, 4'd4, 1'b0, 4);
        step(4'd7, 4'd5, 1'b0, 6);
        check("pre_clr_count_bin", count_bin, 5);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_count_bin", count_bin, 0);
        check("clr_advanced", advanced, 0);
        check("clr_err", err, 0);
        check("clr_empty", empty, 1);
        push_exp(4'd5, 4'd5, 1'b0);
        repeat (6) @(negedge clk);

        // Clr held several cycles with gry_in=0 keeps everything at 0.
        clr    = 1'b1;
        gry_in = '0;
        repeat (3) begin
            @(negedge clk);
            check("clr_hold_count_bin", count_bin, 0);
        end
        clr = 1'b0;
        repeat (4) @(negedge clk);

        // Two-bit jump 0 -> 3, then a legal step, then clr.
        step(4'd3, 4'd2, ERR_EN, 5);
        step(4'd2, 4'd3, ERR_EN, 5);
        check("err_hold", err, ERR_EN);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("err_clr", err, 0);
        push_exp(4'd3, 4'd3, 1'b0);
        repeat (6) @(negedge clk);

        // Asynchronous reset between edges, then refill with Gray(4)=6.
        local_bin = 4'd3;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count_bin", count_bin, 0);
        check("arst_advanced", advanced, 0);
        check("arst_err", err, 0);
        check("arst_level", level, 13);
        gry_in = 4'd6;
        @(negedge clk);
        rst = 1'b0;
        push_exp(4'd4, 4'd1, 1'b0);
        repeat (6) @(negedge clk);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
